// File: rtl/cm3_code_arbiter.sv
// -----------------------------------------------------------------------------
// cm3_code_arbiter
//
// N-master AHB-Lite arbiter/multiplexer for the Cortex-M3 code region. It sits
// between the code-side masters (ICode, DCode, debug, DMA, ...) and the single
// code-memory slave port.
//
// Each master has an address holding register. A master that loses arbitration,
// or wins while the code bus is stalled, has its address phase captured and is
// stalled through HREADYM until the held transfer has been issued and its data
// phase completes. Nothing is dropped.
//
// Arbitration is fixed priority (ARB_MODE=0, lowest index wins) or round-robin
// (ARB_MODE=1). An accepted NONSEQ of a multi-beat burst locks the bus to its
// master while that master keeps presenting SEQ/BUSY.
//
// Handshake semantics (one rule for every port): an address phase presented
// with HTRANS[1]=1 is taken by this block at a rising HCLK edge where the
// matching HREADY seen by that master is 1. On the code side, an address phase
// on HADDRC/HTRANSC is accepted by the slave at an edge where HREADYC=1. A data
// phase completes at the edge where the relevant HREADY is 1.
//
// Ports (N = NUM_MASTERS; master m owns slice m of each flattened vector)
//   HCLK, HRESET               clock, asynchronous active-high reset
//   HADDRM/HTRANSM/HWRITEM/HSIZEM/HBURSTM/HPROTM/EXREQM
//                              master address phase inputs
//   HWDATAM                    master write data (data phase)
//   HREADYM/HRESPM/EXRESPM     per-master ready / response / exclusive response
//   HRDATAM                    per-master read data (HRDATAC broadcast)
//   HADDRC/HTRANSC/HWRITEC/HSIZEC/HBURSTC/HPROTC/EXREQC
//                              code-bus address phase outputs
//   HWDATAC                    code-bus write data of the data-phase owner
//   HMASTERC                   index of the master owning the address phase
//   HRDATAC/HREADYC/HRESPC/EXRESPC
//                              code-bus slave response inputs
// -----------------------------------------------------------------------------
module cm3_code_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int MID_WIDTH   = 1
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDRM,
  input  logic [NUM_MASTERS*2-1:0]          HTRANSM,
  input  logic [NUM_MASTERS-1:0]            HWRITEM,
  input  logic [NUM_MASTERS*3-1:0]          HSIZEM,
  input  logic [NUM_MASTERS*3-1:0]          HBURSTM,
  input  logic [NUM_MASTERS*4-1:0]          HPROTM,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATAM,
  input  logic [NUM_MASTERS-1:0]            EXREQM,
  output logic [NUM_MASTERS-1:0]            HREADYM,
  output logic [NUM_MASTERS*2-1:0]          HRESPM,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] HRDATAM,
  output logic [NUM_MASTERS-1:0]            EXRESPM,
  output logic [ADDR_WIDTH-1:0]             HADDRC,
  output logic [1:0]                        HTRANSC,
  output logic                              HWRITEC,
  output logic [2:0]                        HSIZEC,
  output logic [2:0]                        HBURSTC,
  output logic [3:0]                        HPROTC,
  output logic                              EXREQC,
  output logic [DATA_WIDTH-1:0]             HWDATAC,
  output logic [MID_WIDTH-1:0]              HMASTERC,
  input  logic [DATA_WIDTH-1:0]             HRDATAC,
  input  logic                              HREADYC,
  input  logic [1:0]                        HRESPC,
  input  logic                              EXRESPC
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] BURST_SINGLE = 3'b000;

  // One address phase worth of control.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  exreq;
  } aphase_t;

  // Arbiter state, kept together so it can be observed as one value.
  typedef struct packed {
    logic                 lock;
    logic [MID_WIDTH-1:0] lock_id;
    logic [MID_WIDTH-1:0] rr_ptr;
  } arb_state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  arb_state_t           r_arb;
  logic [NUM_MASTERS-1:0] r_pend;
  aphase_t              r_hold [NUM_MASTERS];
  aphase_t              r_last;
  logic [MID_WIDTH-1:0] r_last_mid;
  logic                 r_dvalid;
  logic [MID_WIDTH-1:0] r_owner;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  aphase_t                w_live_ap [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_wdata_m [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_is_owner;
  logic [NUM_MASTERS-1:0] w_live;
  logic [NUM_MASTERS-1:0] w_cand;
  logic [NUM_MASTERS-1:0] w_sel;
  logic [NUM_MASTERS-1:0] w_capture;
  logic [NUM_MASTERS-1:0] w_clear;
  logic [MID_WIDTH-1:0]   w_win_fix;
  logic [MID_WIDTH-1:0]   w_win_rr;
  logic [MID_WIDTH-1:0]   w_win;
  logic [MID_WIDTH-1:0]   w_rr_next;
  logic                   w_lock_eff;
  logic                   w_has_win;
  logic                   w_src_nonseq;
  aphase_t                w_src;
  aphase_t                w_out;

  // ---------------------------------------------------------------------------
  // Per-master unpacking and response routing
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    assign w_live_ap[g] = '{addr:  HADDRM[g*ADDR_WIDTH +: ADDR_WIDTH],
                            trans: HTRANSM[g*2 +: 2],
                            write: HWRITEM[g],
                            size:  HSIZEM[g*3 +: 3],
                            burst: HBURSTM[g*3 +: 3],
                            prot:  HPROTM[g*4 +: 4],
                            exreq: EXREQM[g]};
    assign w_wdata_m[g]  = HWDATAM[g*DATA_WIDTH +: DATA_WIDTH];

    assign w_is_owner[g] = r_dvalid & (r_owner == MID_WIDTH'(g));

    // In its own data phase a master follows the slave; otherwise it is only
    // stalled while a transfer of its own is still held here.
    assign HREADYM[g] = w_is_owner[g] ? HREADYC : ~r_pend[g];
    assign HRESPM[g*2 +: 2] = w_is_owner[g] ? HRESPC : 2'b00;
    assign EXRESPM[g] = w_is_owner[g] & EXRESPC;
    assign HRDATAM[g*DATA_WIDTH +: DATA_WIDTH] = HRDATAC;

    // Requests are ignored while reset is asserted so the code bus stays IDLE.
    assign w_live[g] = ~HRESET & HTRANSM[g*2+1] & HREADYM[g];
    assign w_cand[g] = r_pend[g] | w_live[g];
    assign w_sel[g]  = w_has_win & (w_win == MID_WIDTH'(g));

    // A live request is captured unless it is passed straight through and
    // accepted this cycle. This also covers a winner whose older held transfer
    // is the one being issued: the new request replaces it in the hold slot.
    assign w_capture[g] = w_live[g] & ~(w_sel[g] & ~r_pend[g] & HREADYC);
    assign w_clear[g]   = w_sel[g] & r_pend[g] & HREADYC;
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // The lock only constrains the bus while its master is mid-burst (SEQ/BUSY
  // both have HTRANS[0]=1); an IDLE or NONSEQ from it reopens arbitration at
  // once, so a waiting master is issued directly after the last beat.
  assign w_lock_eff = r_arb.lock & w_live_ap[r_arb.lock_id].trans[0];

  always_comb begin
    w_win_fix = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win_fix = MID_WIDTH'(i);
    end
    // Round-robin: lowest candidate at or above the pointer, else wrap around
    // to the lowest candidate overall.
    w_win_rr = w_win_fix;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_cand[i] && (MID_WIDTH'(i) >= r_arb.rr_ptr)) w_win_rr = MID_WIDTH'(i);
    end
  end

  assign w_win     = w_lock_eff ? r_arb.lock_id : ((ARB_MODE == 1) ? w_win_rr : w_win_fix);
  // A locked master keeps the bus even while presenting BUSY.
  assign w_has_win = w_lock_eff | (|w_cand);
  assign w_rr_next = (w_win == MID_WIDTH'(NUM_MASTERS - 1)) ? '0 : w_win + MID_WIDTH'(1);

  // A held transfer takes precedence over the live inputs of the same master.
  assign w_src        = r_pend[w_win] ? r_hold[w_win] : w_live_ap[w_win];
  assign w_src_nonseq = w_has_win & (w_src.trans == TRANS_NONSEQ);

  // With no winner the address bus parks on the last winner's values; r_last
  // always stores IDLE as its transfer type.
  assign w_out = w_has_win ? w_src : r_last;

  // ---------------------------------------------------------------------------
  // Code-bus outputs
  // ---------------------------------------------------------------------------
  assign HADDRC   = w_out.addr;
  assign HTRANSC  = w_out.trans;
  assign HWRITEC  = w_out.write;
  assign HSIZEC   = w_out.size;
  assign HBURSTC  = w_out.burst;
  assign HPROTC   = w_out.prot;
  assign EXREQC   = w_out.exreq;
  assign HMASTERC = w_has_win ? w_win : r_last_mid;
  assign HWDATAC  = w_wdata_m[r_owner];

  // ---------------------------------------------------------------------------
  // Arbiter state, data-phase owner and parked address
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_arb      <= '0;
      r_dvalid   <= 1'b0;
      r_owner    <= '0;
      r_last     <= '0;
      r_last_mid <= '0;
    end else begin
      if (w_has_win) begin
        r_last       <= w_src;
        r_last.trans <= TRANS_IDLE;
        r_last_mid   <= w_win;
      end
      if (HREADYC) begin
        r_dvalid <= w_has_win & w_src.trans[1];
        if (w_has_win) r_owner <= w_win;
        if (w_src_nonseq) r_arb.rr_ptr <= w_rr_next;
        if (w_src_nonseq && (w_src.burst != BURST_SINGLE)) begin
          r_arb.lock    <= 1'b1;
          r_arb.lock_id <= w_win;
        end else if (!w_lock_eff) begin
          r_arb.lock <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Holding registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_capture[i]) begin
          r_pend[i] <= 1'b1;
          r_hold[i] <= w_live_ap[i];
        end else if (w_clear[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cm3_code_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for cm3_code_arbiter: a 2-master fixed-priority instance (dut_a) and a
// 3-master round-robin instance (dut_b) share clock, reset and slave inputs.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_cm3_code_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared slave side
  logic [31:0] hrdatac;
  logic        hreadyc;
  logic [1:0]  hrespc;
  logic        exrespc;

  // dut_a: N=2, fixed priority
  logic [63:0] a_haddrm;
  logic [3:0]  a_htransm;
  logic [1:0]  a_hwritem;
  logic [5:0]  a_hsizem;
  logic [5:0]  a_hburstm;
  logic [7:0]  a_hprotm;
  logic [63:0] a_hwdatam;
  logic [1:0]  a_exreqm;
  logic [1:0]  a_hreadym;
  logic [3:0]  a_hrespm;
  logic [63:0] a_hrdatam;
  logic [1:0]  a_exrespm;
  logic [31:0] a_haddrc;
  logic [1:0]  a_htransc;
  logic        a_hwritec;
  logic [2:0]  a_hsizec;
  logic [2:0]  a_hburstc;
  logic [3:0]  a_hprotc;
  logic        a_exreqc;
  logic [31:0] a_hwdatac;
  logic [0:0]  a_hmasterc;

  // dut_b: N=3, round-robin
  logic [95:0] b_haddrm;
  logic [5:0]  b_htransm;
  logic [2:0]  b_hwritem;
  logic [8:0]  b_hsizem;
  logic [8:0]  b_hburstm;
  logic [11:0] b_hprotm;
  logic [95:0] b_hwdatam;
  logic [2:0]  b_exreqm;
  logic [2:0]  b_hreadym;
  logic [5:0]  b_hrespm;
  logic [95:0] b_hrdatam;
  logic [2:0]  b_exrespm;
  logic [31:0] b_haddrc;
  logic [1:0]  b_htransc;
  logic        b_hwritec;
  logic [2:0]  b_hsizec;
  logic [2:0]  b_hburstc;
  logic [3:0]  b_hprotc;
  logic        b_exreqc;
  logic [31:0] b_hwdatac;
  logic [1:0]  b_hmasterc;

  cm3_code_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .MID_WIDTH(1)
  ) dut_a (
    .HCLK(clk), .HRESET(rst),
    .HADDRM(a_haddrm), .HTRANSM(a_htransm), .HWRITEM(a_hwritem), .HSIZEM(a_hsizem),
    .HBURSTM(a_hburstm), .HPROTM(a_hprotm), .HWDATAM(a_hwdatam), .EXREQM(a_exreqm),
    .HREADYM(a_hreadym), .HRESPM(a_hrespm), .HRDATAM(a_hrdatam), .EXRESPM(a_exrespm),
    .HADDRC(a_haddrc), .HTRANSC(a_htransc), .HWRITEC(a_hwritec), .HSIZEC(a_hsizec),
    .HBURSTC(a_hburstc), .HPROTC(a_hprotc), .EXREQC(a_exreqc), .HWDATAC(a_hwdatac),
    .HMASTERC(a_hmasterc), .HRDATAC(hrdatac), .HREADYC(hreadyc), .HRESPC(hrespc),
    .EXRESPC(exrespc)
  );

  cm3_code_arbiter #(
    .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .MID_WIDTH(2)
  ) dut_b (
    .HCLK(clk), .HRESET(rst),
    .HADDRM(b_haddrm), .HTRANSM(b_htransm), .HWRITEM(b_hwritem), .HSIZEM(b_hsizem),
    .HBURSTM(b_hburstm), .HPROTM(b_hprotm), .HWDATAM(b_hwdatam), .EXREQM(b_exreqm),
    .HREADYM(b_hreadym), .HRESPM(b_hrespm), .HRDATAM(b_hrdatam), .EXRESPM(b_exrespm),
    .HADDRC(b_haddrc), .HTRANSC(b_htransc), .HWRITEC(b_hwritec), .HSIZEC(b_hsizec),
    .HBURSTC(b_hburstc), .HPROTC(b_hprotc), .EXREQC(b_exreqc), .HWDATAC(b_hwdatac),
    .HMASTERC(b_hmasterc), .HRDATAC(hrdatac), .HREADYC(hreadyc), .HRESPC(hrespc),
    .EXRESPC(exrespc)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic a_req(input int m, input logic [1:0] t, input logic [31:0] addr,
                       input logic wr, input logic [2:0] bst);
    a_htransm[m*2 +: 2]  = t;
    a_haddrm[m*32 +: 32] = addr;
    a_hwritem[m]         = wr;
    a_hburstm[m*3 +: 3]  = bst;
  endtask

  task automatic b_req(input int m, input logic [1:0] t, input logic [31:0] addr);
    b_htransm[m*2 +: 2]  = t;
    b_haddrm[m*32 +: 32] = addr;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] got_m;
    logic [1:0] exp_m;
    int wait_cnt [3];
    int max_wait;

    hrdatac = '0; hreadyc = 1'b1; hrespc = 2'b00; exrespc = 1'b0;
    a_haddrm = '0; a_htransm = '0; a_hwritem = '0; a_hsizem = 6'b010_010;
    a_hburstm = '0; a_hprotm = 8'h33; a_hwdatam = '0; a_exreqm = '0;
    b_haddrm = '0; b_htransm = '0; b_hwritem = '0; b_hsizem = 9'b010_010_010;
    b_hburstm = '0; b_hprotm = 12'h333; b_hwdatam = '0; b_exreqm = '0;

    // Reset: a request presented during reset must not reach the code bus.
    a_req(0, NONSEQ, 32'h10, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_hreadym",  a_hreadym, 2'b11);
    check_eq("rst_hrespm",   a_hrespm, 4'b0000);
    check_eq("rst_htransc",  a_htransc, IDLE);
    check_eq("rst_hmasterc", a_hmasterc, 0);
    check_eq("rst_exrespm",  a_exrespm, 2'b00);
    check_eq("rst_b_hreadym", b_hreadym, 3'b111);
    a_req(0, IDLE, 32'h0, 1'b0, 3'b000);
    rst = 1'b0;
    step();

    // M1 alone: zero-latency pass-through, read data broadcast.
    a_req(1, NONSEQ, 32'h100, 1'b0, 3'b000);
    #1;
    check_eq("m1_alone_addr",   a_haddrc, 32'h100);
    check_eq("m1_alone_trans",  a_htransc, NONSEQ);
    check_eq("m1_alone_master", a_hmasterc, 1);
    step();
    a_req(1, IDLE, 32'h0, 1'b0, 3'b000);
    hrdatac = 32'hA5A5_A5A5; exrespc = 1'b1;
    #1;
    check_eq("m1_alone_rdata",  a_hrdatam[63:32], 32'hA5A5_A5A5);
    check_eq("m1_alone_ready",  a_hreadym, 2'b11);
    check_eq("m1_alone_exresp", a_exrespm, 2'b10);
    step();
    hrdatac = '0; exrespc = 1'b0;

    // Simultaneous M0/M1: M0 first, M1 held and issued next cycle.
    a_req(0, NONSEQ, 32'h0, 1'b0, 3'b000);
    a_req(1, NONSEQ, 32'h40, 1'b0, 3'b000);
    #1;
    check_eq("both_addr0",  a_haddrc, 32'h0);
    check_eq("both_mst0",   a_hmasterc, 0);
    check_eq("both_ready0", a_hreadym, 2'b11);
    step();
    a_req(0, IDLE, 32'h0, 1'b0, 3'b000);
    a_req(1, IDLE, 32'h0, 1'b0, 3'b000);
    #1;
    check_eq("held_addr",  a_haddrc, 32'h40);
    check_eq("held_trans", a_htransc, NONSEQ);
    check_eq("held_mst",   a_hmasterc, 1);
    check_eq("held_ready", a_hreadym, 2'b01);
    step();
    hreadyc = 1'b0;
    #1;
    check_eq("held_dphase_wait", a_hreadym, 2'b01);
    check_eq("held_dphase_idle", a_htransc, IDLE);
    step();
    hreadyc = 1'b1;
    #1;
    check_eq("held_dphase_done", a_hreadym, 2'b11);
    step();

    // INCR4 burst from M1; M0 arrives on beat 2 and waits for the burst end.
    a_req(1, NONSEQ, 32'h80, 1'b0, 3'b011);
    #1;
    check_eq("burst_b0_addr",  a_haddrc, 32'h80);
    check_eq("burst_b0_burst", a_hburstc, 3'b011);
    check_eq("burst_b0_mst",   a_hmasterc, 1);
    step();
    a_req(1, SEQ, 32'h84, 1'b0, 3'b011);
    a_req(0, NONSEQ, 32'h300, 1'b0, 3'b000);
    #1;
    check_eq("burst_b1_addr",  a_haddrc, 32'h84);
    check_eq("burst_b1_trans", a_htransc, SEQ);
    check_eq("burst_b1_mst",   a_hmasterc, 1);
    step();
    a_req(0, IDLE, 32'h0, 1'b0, 3'b000);
    a_req(1, SEQ, 32'h88, 1'b0, 3'b011);
    #1;
    check_eq("burst_b2_addr",  a_haddrc, 32'h88);
    check_eq("burst_b2_ready", a_hreadym, 2'b10);
    step();
    a_req(1, SEQ, 32'h8C, 1'b0, 3'b011);
    #1;
    check_eq("burst_b3_addr", a_haddrc, 32'h8C);
    check_eq("burst_b3_mst",  a_hmasterc, 1);
    step();
    a_req(1, IDLE, 32'h0, 1'b0, 3'b000);
    #1;
    check_eq("burst_m0_addr",  a_haddrc, 32'h300);
    check_eq("burst_m0_mst",   a_hmasterc, 0);
    check_eq("burst_m0_trans", a_htransc, NONSEQ);
    step();
    #1;
    check_eq("burst_m0_ready", a_hreadym, 2'b11);
    check_eq("burst_m0_idle",  a_htransc, IDLE);
    step();

    // Two-cycle ERROR response on an M1 write.
    a_req(1, NONSEQ, 32'h200, 1'b1, 3'b000);
    #1;
    check_eq("err_addr",  a_haddrc, 32'h200);
    check_eq("err_write", a_hwritec, 1'b1);
    step();
    a_req(1, IDLE, 32'h0, 1'b0, 3'b000);
    a_hwdatam = {32'hDEAD_BEEF, 32'h1111_1111};
    hrespc = 2'b01; hreadyc = 1'b0;
    #1;
    check_eq("err_c1_resp",  a_hrespm, 4'b0100);
    check_eq("err_c1_ready", a_hreadym, 2'b01);
    check_eq("err_wdata",    a_hwdatac, 32'hDEAD_BEEF);
    step();
    hreadyc = 1'b1;
    #1;
    check_eq("err_c2_resp",  a_hrespm, 4'b0100);
    check_eq("err_c2_ready", a_hreadym, 2'b11);
    step();
    hrespc = 2'b00;
    a_hwdatam = '0;

    // Reset while M1 has a held transfer.
    a_req(0, NONSEQ, 32'h500, 1'b0, 3'b000);
    a_req(1, NONSEQ, 32'h600, 1'b0, 3'b000);
    #1;
    check_eq("rstp_mst0", a_hmasterc, 0);
    step();
    a_req(0, IDLE, 32'h0, 1'b0, 3'b000);
    a_req(1, IDLE, 32'h0, 1'b0, 3'b000);
    #1;
    check_eq("rstp_held_addr", a_haddrc, 32'h600);
    check_eq("rstp_held_rdy",  a_hreadym, 2'b01);
    rst = 1'b1;
    #1;
    check_eq("rstp_ready", a_hreadym, 2'b11);
    check_eq("rstp_trans", a_htransc, IDLE);
    check_eq("rstp_mst",   a_hmasterc, 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("rstp_after_trans", a_htransc, IDLE);
    check_eq("rstp_after_ready", a_hreadym, 2'b11);
    step();
    #1;
    check_eq("rstp_no_stale", a_htransc, IDLE);
    step();

    // Round-robin, all three masters requesting continuously.
    for (int m = 0; m < 3; m++) begin
      b_req(m, NONSEQ, 32'h1000 + 32'(m) * 32'h10);
      wait_cnt[m] = 0;
    end
    max_wait = 0;
    for (int c = 0; c < 6; c++) exp_q.push_back(2'(c % 3));
    for (int c = 0; c < 6; c++) begin
      #1;
      got_m = b_hmasterc;
      exp_m = exp_q.pop_front();
      check_eq("rr_grant", got_m, exp_m);
      check_eq("rr_addr", b_haddrc, 32'h1000 + 32'(exp_m) * 32'h10);
      for (int m = 0; m < 3; m++) begin
        if (got_m == 2'(m)) wait_cnt[m] = 0;
        else wait_cnt[m]++;
        if (wait_cnt[m] > max_wait) max_wait = wait_cnt[m];
      end
      step();
    end
    check_eq("rr_max_wait", max_wait, 2);
    for (int m = 0; m < 3; m++) b_req(m, IDLE, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
